aurora_link_monitor: RTL and testbench

AURORA_LINK_MONITOR -- requirements
Module: aurora_link_monitor

---
 rtl/aurora_link_monitor.sv | 150 +++++++++++++++
 tb/tb_aurora_link_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_link_monitor.sv
// Aurora link supervisor: pulses the core reset, qualifies link-up with debounce, and retries up to a limit.
// Optional build macro LINK_ERR_CNT_EN adds saturating soft/hard error cycle counters active while UP.
module aurora_link_monitor #(
  parameter int LANES         = 4,
  parameter int DOWN_DEBOUNCE = 16,
  parameter int RESET_HOLD    = 128,
  parameter int UP_TIMEOUT    = 1048576,
  parameter int MAX_RETRY     = 7
) (
  input  logic             aurora_log_clk,
  input  logic             aurora_rst,
  input  logic             channel_up_i,
  input  logic [LANES-1:0] lane_up_i,
  input  logic             hard_err_i,
  input  logic             soft_err_i,
  input  logic             retry_clr_i,
  output logic             link_reset_o,
  output logic             link_ok_o,
  output logic             link_fail_o,
  output logic [3:0]       retry_cnt_o,
  output logic [15:0]      soft_err_cnt_o,
  output logic [15:0]      hard_err_cnt_o
);

  localparam int TMR_W  = ($clog2(UP_TIMEOUT) > 21) ? $clog2(UP_TIMEOUT) : 21;
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int DEB_W  = $clog2(DOWN_DEBOUNCE + 1);

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(UP_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DOWN_DEBOUNCE - 1);
  localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_RST,
    ST_WAIT_UP,
    ST_UP,
    ST_FAIL
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  tmr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic              link_good;

  assign link_good = channel_up_i & (&lane_up_i);

  // NOTE: all state and registered outputs use <= so every branch sees pre-edge values.
  always_ff @(posedge aurora_log_clk) begin
    if (aurora_rst) begin
      state        <= ST_RST;
      tmr          <= '0;
      hold_cnt     <= '0;
      deb_cnt      <= '0;
      link_reset_o <= 1'b1;
      link_ok_o    <= 1'b0;
      link_fail_o  <= 1'b0;
      retry_cnt_o  <= '0;
    end else begin
      case (state)
        ST_RST: begin
          // The hold counter stays at its terminal value after leaving RST.
          if (hold_cnt == HOLD_LAST) begin
            state        <= ST_WAIT_UP;
            link_reset_o <= 1'b0;
            tmr          <= '0;
            deb_cnt      <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_WAIT_UP: begin
          // Qualification is tested first so it wins over a coincident timeout.
          if (link_good && deb_cnt == DEB_LAST) begin
            state       <= ST_UP;
            link_ok_o   <= 1'b1;
            retry_cnt_o <= '0;
            deb_cnt     <= '0;
          end else if (tmr == TMR_LAST) begin
            if (retry_cnt_o < RETRY_MAX) begin
              state        <= ST_RST;
              retry_cnt_o  <= retry_cnt_o + 1'b1;
              link_reset_o <= 1'b1;
              hold_cnt     <= '0;
            end else begin
              state       <= ST_FAIL;
              link_fail_o <= 1'b1;
            end
          end else begin
            tmr     <= tmr + 1'b1;
            deb_cnt <= link_good ? deb_cnt + 1'b1 : '0;
          end
        end

        ST_UP: begin
          if (hard_err_i || (!link_good && deb_cnt == DEB_LAST)) begin
            state        <= ST_RST;
            link_ok_o    <= 1'b0;
            link_reset_o <= 1'b1;
            hold_cnt     <= '0;
            deb_cnt      <= '0;
          end else begin
            deb_cnt <= link_good ? '0 : deb_cnt + 1'b1;
          end
        end

        ST_FAIL: begin
          if (retry_clr_i) begin
            state        <= ST_RST;
            link_fail_o  <= 1'b0;
            link_reset_o <= 1'b1;
            hold_cnt     <= '0;
          end
        end

        default: begin
          state        <= ST_RST;
          link_reset_o <= 1'b1;
          link_ok_o    <= 1'b0;
          link_fail_o  <= 1'b0;
          hold_cnt     <= '0;
        end
      endcase

      // A clear overrides any increment taken above, in every state.
      if (retry_clr_i) retry_cnt_o <= '0;
    end
  end

`ifdef LINK_ERR_CNT_EN
  always_ff @(posedge aurora_log_clk) begin
    if (aurora_rst || retry_clr_i) begin
      soft_err_cnt_o <= '0;
      hard_err_cnt_o <= '0;
    end else if (state == ST_UP) begin
      if (soft_err_i && soft_err_cnt_o != 16'hFFFF) soft_err_cnt_o <= soft_err_cnt_o + 1'b1;
      if (hard_err_i && hard_err_cnt_o != 16'hFFFF) hard_err_cnt_o <= hard_err_cnt_o + 1'b1;
    end
  end
`else
  logic unused_soft_err;

  assign unused_soft_err = soft_err_i;
  assign soft_err_cnt_o  = '0;
  assign hard_err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_aurora_link_monitor.sv
// Scoreboard bench for aurora_link_monitor: expected output vectors are queued with a due cycle
// and compared by a negedge monitor; covers reset, debounce, retries, FAIL and optional error counters.
module tb_aurora_link_monitor;

  localparam int LANES = 4;

  logic        clk_100m = 1'b0;
  logic        aurora_rst;
  logic        channel_up_i;
  logic [3:0]  lane_up_i;
  logic        hard_err_i;
  logic        soft_err_i;
  logic        retry_clr_i;
  logic        link_reset_o;
  logic        link_ok_o;
  logic        link_fail_o;
  logic [3:0]  retry_cnt_o;
  logic [15:0] soft_err_cnt_o;
  logic [15:0] hard_err_cnt_o;

  always #5 clk_100m = ~clk_100m;

  aurora_link_monitor #(
    .LANES(LANES), .DOWN_DEBOUNCE(4), .RESET_HOLD(8), .UP_TIMEOUT(100), .MAX_RETRY(2)
  ) dut (
    .aurora_log_clk(clk_100m),
    .aurora_rst    (aurora_rst),
    .channel_up_i  (channel_up_i),
    .lane_up_i     (lane_up_i),
    .hard_err_i    (hard_err_i),
    .soft_err_i    (soft_err_i),
    .retry_clr_i   (retry_clr_i),
    .link_reset_o  (link_reset_o),
    .link_ok_o     (link_ok_o),
    .link_fail_o   (link_fail_o),
    .retry_cnt_o   (retry_cnt_o),
    .soft_err_cnt_o(soft_err_cnt_o),
    .hard_err_cnt_o(hard_err_cnt_o)
  );

  // Output vector layout: {link_reset, link_ok, link_fail, retry_cnt[3:0]}
  localparam logic [6:0] V_RST  = 7'b100_0000;
  localparam logic [6:0] V_WAIT = 7'b000_0000;
  localparam logic [6:0] V_UP   = 7'b010_0000;

  typedef struct {
    string      tag;
    int         at;
    logic [6:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clk_100m) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] outs();
    return {link_reset_o, link_ok_o, link_fail_o, retry_cnt_o};
  endfunction

  task automatic expect_at(input string tag, input int dly, input logic [6:0] v);
    sb_item_t it;
    it.tag = tag;
    it.at  = cyc + dly;
    it.exp = v;
    sb.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100m);
  endtask

  // Compare every queued expectation that falls due after the most recent rising edge.
  always @(negedge clk_100m) begin : sb_monitor
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].at == cyc) begin
        check(sb[i].tag, 32'(outs()), 32'(sb[i].exp));
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    aurora_rst   = 1'b1;
    channel_up_i = 1'b1;
    lane_up_i    = 4'hF;
    hard_err_i   = 1'b0;
    soft_err_i   = 1'b0;
    retry_clr_i  = 1'b0;
    tick(3);
    check("reset_state", 32'(outs()), 32'(V_RST));
    check("reset_soft_cnt", 32'(soft_err_cnt_o), 32'd0);
    check("reset_hard_cnt", 32'(hard_err_cnt_o), 32'd0);

    // Link good from release: 8 hold cycles, then UP after 4 good cycles in WAIT_UP
    aurora_rst = 1'b0;
    expect_at("s1_hold_last", 7, V_RST);
    expect_at("s1_hold_done", 8, V_WAIT);
    expect_at("s1_pre_up", 11, V_WAIT);
    expect_at("s1_up", 12, V_UP);
    tick(14);

    // Three-cycle channel drop is absorbed; four cycles drops the link
    channel_up_i = 1'b0;
    expect_at("s2_glitch3_mid", 3, V_UP);
    expect_at("s2_glitch3_after", 5, V_UP);
    tick(3);
    channel_up_i = 1'b1;
    tick(3);
    channel_up_i = 1'b0;
    expect_at("s2_low3_up", 3, V_UP);
    expect_at("s2_low4_rst", 4, V_RST);
    expect_at("s2_rehold_last", 11, V_RST);
    expect_at("s2_rewait", 12, V_WAIT);
    expect_at("s2_reup", 16, V_UP);
    tick(4);
    channel_up_i = 1'b1;
    tick(14);

    // Soft errors never affect state; counted only when the option is built
    soft_err_i = 1'b1;
    tick(20);
    soft_err_i = 1'b0;
    tick(1);
    check("s3_still_up", 32'(outs()), 32'(V_UP));
`ifdef LINK_ERR_CNT_EN
    check("s3_soft_cnt", 32'(soft_err_cnt_o), 32'd20);
`else
    check("s3_soft_cnt", 32'(soft_err_cnt_o), 32'd0);
`endif

    // Hard error drops the link at once; a missing lane then blocks qualification through every retry
    hard_err_i = 1'b1;
    lane_up_i  = 4'b0111;
    expect_at("s4_hard_rst", 1, V_RST);
    expect_at("s4_hold_last", 8, V_RST);
    expect_at("s4_wait", 9, V_WAIT);
    expect_at("s4_no_qual", 13, V_WAIT);
    expect_at("s4_pre_to1", 108, V_WAIT);
    expect_at("s4_to1_retry1", 109, 7'b100_0001);
    expect_at("s4_hold2_last", 116, 7'b100_0001);
    expect_at("s4_wait2", 117, 7'b000_0001);
    expect_at("s4_pre_to2", 216, 7'b000_0001);
    expect_at("s4_to2_retry2", 217, 7'b100_0010);
    expect_at("s4_hold3_last", 224, 7'b100_0010);
    expect_at("s4_wait3", 225, 7'b000_0010);
    expect_at("s4_pre_to3", 324, 7'b000_0010);
    expect_at("s4_fail", 325, 7'b001_0010);
    expect_at("s4_fail_held", 360, 7'b001_0010);
    tick(1);
    hard_err_i = 1'b0;
`ifdef LINK_ERR_CNT_EN
    check("s4_hard_cnt", 32'(hard_err_cnt_o), 32'd1);
`else
    check("s4_hard_cnt", 32'(hard_err_cnt_o), 32'd0);
`endif
    tick(369);

    // Clear from FAIL restarts; clear during RST zeroes retries without disturbing the hold
    retry_clr_i = 1'b1;
    expect_at("s5_clr_rst", 1, V_RST);
    tick(1);
    retry_clr_i = 1'b0;
    expect_at("s5_retry1", 108, 7'b100_0001);
    tick(108);
    retry_clr_i = 1'b1;
    expect_at("s5_clr_mid_rst", 1, V_RST);
    tick(1);
    retry_clr_i = 1'b0;
    lane_up_i   = 4'hF;
    expect_at("s5_hold_last", 6, V_RST);
    expect_at("s5_wait", 7, V_WAIT);
    expect_at("s5_up", 11, V_UP);
    tick(13);
    check("s5_hard_cnt_clr", 32'(hard_err_cnt_o), 32'd0);

`ifdef LINK_ERR_CNT_EN
    soft_err_i = 1'b1;
    tick(70000);
    soft_err_i = 1'b0;
    tick(1);
    check("s6_soft_sat", 32'(soft_err_cnt_o), 32'h0000_FFFF);
    check("s6_up_after_soft", 32'(outs()), 32'(V_UP));
`endif

    // Reset asserted mid-hold restarts the full 8-cycle hold and clears counters
    hard_err_i = 1'b1;
    tick(1);
    hard_err_i = 1'b0;
    tick(3);
    aurora_rst = 1'b1;
    tick(2);
    check("s6_rst_state", 32'(outs()), 32'(V_RST));
    check("s6_rst_soft", 32'(soft_err_cnt_o), 32'd0);
    check("s6_rst_hard", 32'(hard_err_cnt_o), 32'd0);
    aurora_rst = 1'b0;
    expect_at("s6_hold_last", 7, V_RST);
    expect_at("s6_hold_done", 8, V_WAIT);
    expect_at("s6_up", 12, V_UP);
    tick(14);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
